// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared width codes, data width and FSM states for the data-memory responder
package data_mem_responder_pkg;

    localparam int DMEM_DATA_W = 64;

    // funct3 access-width codes; 3'b111 is accepted and behaves as a doubleword
    localparam logic [2:0] MEM_W_B  = 3'b000;
    localparam logic [2:0] MEM_W_H  = 3'b001;
    localparam logic [2:0] MEM_W_W  = 3'b010;
    localparam logic [2:0] MEM_W_D  = 3'b011;
    localparam logic [2:0] MEM_W_BU = 3'b100;
    localparam logic [2:0] MEM_W_HU = 3'b101;
    localparam logic [2:0] MEM_W_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // log2 of the access size in bytes
    function automatic logic [1:0] width_size_log2(input logic [2:0] width);
        case (width)
            MEM_W_B, MEM_W_BU: width_size_log2 = 2'd0;
            MEM_W_H, MEM_W_HU: width_size_log2 = 2'd1;
            MEM_W_W, MEM_W_WU: width_size_log2 = 2'd2;
            default:           width_size_log2 = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_load_ext.sv
// rtl/data_mem_responder_load_ext.sv - dmem_load_ext: lane shift and sign/zero extension of a read doubleword
module dmem_load_ext
    import data_mem_responder_pkg::*;
(
    input  logic [DMEM_DATA_W-1:0] dword_i,
    input  logic [2:0]             off_i,
    input  logic [2:0]             width_i,
    output logic [DMEM_DATA_W-1:0] data_o
);

    logic [DMEM_DATA_W-1:0] shifted;

    // bring the addressed byte to lane 0, then extend according to the width code
    always_comb begin
        shifted = dword_i >> {off_i, 3'b000};
        case (width_i)
            MEM_W_B:  data_o = {{56{shifted[7]}},  shifted[7:0]};
            MEM_W_H:  data_o = {{48{shifted[15]}}, shifted[15:0]};
            MEM_W_W:  data_o = {{32{shifted[31]}}, shifted[31:0]};
            MEM_W_BU: data_o = {56'd0, shifted[7:0]};
            MEM_W_HU: data_o = {48'd0, shifted[15:0]};
            MEM_W_WU: data_o = {32'd0, shifted[31:0]};
            default:  data_o = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - latency-configurable data-memory responder; DMEM_ALIGN_CHECK_EN enables misalignment errors
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int LATENCY    = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [2:0]             req_width,
    input  logic [DMEM_DATA_W-1:0] req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DMEM_DATA_W-1:0] resp_rdata,
    output logic                   resp_err,
    output logic                   busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    dmem_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [2:0]             width_q, width_d;
    logic [DMEM_DATA_W-1:0] wdata_q, wdata_d;
    logic [DMEM_DATA_W-1:0] rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [DMEM_DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic                   acc_we;
    logic [ADDR_WIDTH-1:0]  acc_addr;
    logic [2:0]             acc_width;
    logic [DMEM_DATA_W-1:0] acc_wdata;
    logic [1:0]             size_log2;
    logic [3:0]             nbytes;
    logic [2:0]             align_mask;
    logic [2:0]             off_raw;
    logic [2:0]             off;
    logic                   misaligned;
    logic                   acc_err;
    logic [IDX_W-1:0]       idx;
    logic [15:0]            lane_base;
    logic [7:0]             lane_mask;
    logic [DMEM_DATA_W-1:0] wdata_sh;
    logic [DMEM_DATA_W-1:0] rd_dword;
    logic [DMEM_DATA_W-1:0] ld_ext;
    logic [DMEM_DATA_W-1:0] commit_rdata;
    logic                   commit;
    logic                   wr_en;
    logic                   unused_bits;

    // with single-cycle latency the commit happens on the accept edge, so use the live request
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_width = req_width;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_width = width_q;
            acc_wdata = wdata_q;
        end
    end

    assign size_log2  = width_size_log2(acc_width);
    assign nbytes     = 4'd1 << size_log2;
    assign align_mask = 3'b111 << size_log2;
    assign off_raw    = acc_addr[2:0];
    assign misaligned = |(off_raw & ~align_mask);

`ifdef DMEM_ALIGN_CHECK_EN
    assign off     = off_raw;
    assign acc_err = misaligned;
`else
    assign off     = off_raw & align_mask;
    assign acc_err = 1'b0;
`endif

    assign idx         = acc_addr[3 +: IDX_W];
    assign lane_base   = (16'd1 << nbytes) - 16'd1;
    assign lane_mask   = lane_base[7:0] << off;
    assign wdata_sh    = acc_wdata << {off, 3'b000};
    assign unused_bits = ^{acc_addr[ADDR_WIDTH-1:3+IDX_W], misaligned};

    assign rd_dword = mem[idx];

    dmem_load_ext u_load_ext (
        .dword_i (rd_dword),
        .off_i   (off),
        .width_i (acc_width),
        .data_o  (ld_ext)
    );

    assign commit_rdata = (acc_we || acc_err) ? '0 : ld_ext;

    // next-state and datapath capture: accept in IDLE, count down in WAIT, hold in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        width_d = width_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    width_d = req_width;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        rdata_d = commit_rdata;
                        err_d   = acc_err;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    rdata_d = commit_rdata;
                    err_d   = acc_err;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // the access commits on the edge that enters RESP; reset on that edge cancels it
    assign commit = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign wr_en  = commit && acc_we && !acc_err && !rst;

    // control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            width_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            width_q <= width_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // byte-lane-masked store into the array; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (lane_mask[i]) begin
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed and random checks of data_mem_responder against a byte-array model
module tb_data_mem_responder;

    localparam int DEPTH     = 512;
    localparam int LATENCY   = 2;
    localparam int AW        = 32;
    localparam int MEM_BYTES = DEPTH * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [2:0]    req_width = '0;
    logic [63:0]   req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [63:0]   resp_rdata;
    logic          resp_err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_m [MEM_BYTES];
    logic [63:0] rd;
    logic        er;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_width  (req_width),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] w);
        case (w)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            default:    return 8;
        endcase
    endfunction

    function automatic logic exp_err(input logic [AW-1:0] addr, input logic [2:0] w);
`ifdef DMEM_ALIGN_CHECK_EN
        return (int'(addr % 32'd8) % size_of(w)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int base_of(input logic [AW-1:0] addr, input logic [2:0] w);
        int n = size_of(w);
        int b = int'(addr % 32'(MEM_BYTES));
        return b - (b % n);
    endfunction

    task automatic model_store(input logic [AW-1:0] addr, input logic [2:0] w, input logic [63:0] wd);
        int n = size_of(w);
        int b = base_of(addr, w);
        if (!exp_err(addr, w))
            for (int i = 0; i < n; i++) mem_m[b + i] = wd[8*i +: 8];
    endtask

    function automatic logic [63:0] model_load(input logic [AW-1:0] addr, input logic [2:0] w);
        int n = size_of(w);
        int b = base_of(addr, w);
        logic [63:0] v = '0;
        if (exp_err(addr, w)) return '0;
        for (int i = 0; i < n; i++) v = v | (64'(mem_m[b + i]) << (8 * i));
        if (n < 8 && !(w inside {3'd4, 3'd5, 3'd6}) && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    // one full request/response transaction; starts and ends just after a rising edge
    task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [2:0] w,
                       input logic [63:0] wd, input int hold,
                       output logic [63:0] rdo, output logic ero);
        int lat;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_width  = w;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = {$urandom, $urandom};
        req_addr  = $urandom;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(LATENCY));
        rdo = resp_rdata;
        ero = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_rdata", resp_rdata, rdo);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_hs_valid", 64'(resp_valid), 64'd0);
        chk("post_hs_req_ready", 64'(req_ready), 64'd1);
    endtask

    task automatic do_store(input logic [AW-1:0] addr, input logic [2:0] w, input logic [63:0] wd, input int hold);
        logic [63:0] r;
        logic        e;
        txn(1'b1, addr, w, wd, hold, r, e);
        chk("store_rdata", r, 64'd0);
        chk("store_err", 64'(e), 64'(exp_err(addr, w)));
        model_store(addr, w, wd);
    endtask

    task automatic do_load(input logic [AW-1:0] addr, input logic [2:0] w, input int hold, output logic [63:0] r);
        logic e;
        txn(1'b0, addr, w, 64'd0, hold, r, e);
        chk("load_err", 64'(e), 64'(exp_err(addr, w)));
        chk("load_model", r, model_load(addr, w));
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem_m[i] = 8'h00;

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // doubleword round trip and byte accesses over the same word
        do_store(32'h10, 3'd3, 64'h1122334455667788, 0);
        do_load(32'h10, 3'd3, 0, rd);
        chk("ld_d_0x10", rd, 64'h1122334455667788);
        do_load(32'h17, 3'd0, 0, rd);
        chk("ld_b_0x17", rd, 64'h0000000000000011);
        do_store(32'h11, 3'd0, 64'h00000000000000F0, 0);
        do_load(32'h11, 3'd0, 0, rd);
        chk("ld_b_0x11", rd, 64'hFFFFFFFFFFFFFFF0);
        do_load(32'h11, 3'd4, 0, rd);
        chk("ld_bu_0x11", rd, 64'h00000000000000F0);

        // word store into the upper half, lower half preserved
        do_store(32'h20, 3'd2, 64'h00000000CAFEBABE, 0);
        do_store(32'h24, 3'd2, 64'h0000000080000001, 0);
        do_load(32'h24, 3'd2, 0, rd);
        chk("ld_w_0x24", rd, 64'hFFFFFFFF80000001);
        do_load(32'h24, 3'd6, 0, rd);
        chk("ld_wu_0x24", rd, 64'h0000000080000001);
        do_load(32'h20, 3'd3, 0, rd);
        chk("ld_d_0x20", rd, 64'h80000001CAFEBABE);

        // backpressure: response frozen while resp_ready is low
        do_load(32'h10, 3'd3, 5, rd);
        chk("ld_d_hold", rd, 64'h112233445566F088);

        // reset in WAIT before the commit edge discards the store
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_width = 3'd3;
        req_wdata = 64'hDEADBEEF01234567;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("wait_rst_busy", 64'(busy), 64'd0);
        chk("wait_rst_resp_valid", 64'(resp_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("wait_rst_quiet", 64'(resp_valid), 64'd0);
        do_load(32'h30, 3'd3, 0, rd);
        chk("ld_d_0x30_discarded", rd, 64'd0);

        // reset in RESP drops the response; the store already committed
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h48; req_width = 3'd3;
        req_wdata = 64'h0F0E0D0C0B0A0908;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !resp_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("resp_rst_pre_valid", 64'(resp_valid), 64'd1);
        model_store(32'h48, 3'd3, 64'h0F0E0D0C0B0A0908);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("resp_rst_valid", 64'(resp_valid), 64'd0);
        chk("resp_rst_rdata", resp_rdata, 64'd0);
        do_load(32'h48, 3'd3, 0, rd);
        chk("ld_d_0x48", rd, 64'h0F0E0D0C0B0A0908);

        // reset and request on the same edge: request is not accepted
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h38; req_width = 3'd3;
        req_wdata = 64'hFFFFFFFFFFFFFFFF;
        rst = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        chk("rst_req_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("rst_req_quiet", 64'(resp_valid), 64'd0);
        do_load(32'h38, 3'd3, 0, rd);
        chk("ld_d_0x38", rd, 64'd0);

        // misaligned halfword store
        do_store(32'h41, 3'd1, 64'h000000000000BEEF, 0);
        do_load(32'h40, 3'd3, 0, rd);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("ld_d_0x40_unchanged", rd, 64'd0);
`else
        chk("ld_d_0x40_forced", rd, 64'h000000000000BEEF);
`endif

        // address wrap: upper bits ignored
        do_store(32'h0001_0058, 3'd3, 64'hA5A5A5A55A5A5A5A, 0);
        do_load(32'h58, 3'd3, 0, rd);
        chk("ld_d_wrap", rd, 64'hA5A5A5A55A5A5A5A);

        // random traffic against the byte model
        for (int k = 0; k < 80; k++) begin
            logic [AW-1:0] a;
            logic [2:0]    w;
            int            h;
            a = AW'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
            w = 3'($urandom_range(0, 7));
            h = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) do_store(a, w, {$urandom, $urandom}, h);
            else do_load(a, w, h, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
